// File: rtl/prog_loader.sv
// Byte-stream program loader: frames N, 4*N big-endian data bytes (and a checksum byte when
// PROG_LOADER_CHECKSUM_EN is defined), writes words to instruction memory, then releases the CPU.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | after reset, waiting for load_req
// S_HDR  | accepting header byte N (word count)
// S_DATA | accepting data bytes, writing one word per four bytes
// S_CSUM | accepting checksum byte, compared with running XOR
// S_DONE | program loaded, CPU released, waiting for load_req
// S_ERR  | bad count or checksum, CPU held, waiting for load_req
module prog_loader #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_req,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst_n,
   output logic              done,
   output logic              err
);

   localparam int CNT_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  n_cnt;
   logic [ADDR_W-1:0] widx;
   logic [1:0]        bidx;
   logic [23:0]       word;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]        acc;
`endif

   logic xfer;
   assign xfer = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_rst_n  <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         n_cnt      <= '0;
         widx       <= '0;
         bidx       <= '0;
         word       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         acc        <= '0;
`endif
      end else begin
         imem_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (load_req) begin
                  state    <= S_HDR;
                  in_ready <= 1'b1;
               end
            end
            S_HDR: begin
               if (xfer) begin
                  if (in_data == 8'd0 || in_data > 8'(DEPTH)) begin
                     state    <= S_ERR;
                     in_ready <= 1'b0;
                     err      <= 1'b1;
                  end else begin
                     n_cnt <= in_data[CNT_W-1:0];
                     widx  <= '0;
                     bidx  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                     acc   <= in_data;
`endif
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (xfer) begin
                  word <= {word[15:0], in_data};
                  bidx <= bidx + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                  acc  <= acc ^ in_data;
`endif
                  if (bidx == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= widx;
                     imem_wdata <= {word, in_data};
                     // Leave DATA on the last word so the state change lands with its write pulse.
                     if ({1'b0, widx} == n_cnt - CNT_W'(1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state <= S_CSUM;
`else
                        state     <= S_DONE;
                        in_ready  <= 1'b0;
                        done      <= 1'b1;
                        cpu_rst_n <= 1'b1;
`endif
                     end else begin
                        widx <= widx + ADDR_W'(1);
                     end
                  end
               end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (xfer) begin
                  in_ready <= 1'b0;
                  if (in_data == acc) begin
                     state     <= S_DONE;
                     done      <= 1'b1;
                     cpu_rst_n <= 1'b1;
                  end else begin
                     state <= S_ERR;
                     err   <= 1'b1;
                  end
               end
            end
`endif
            S_DONE: begin
               if (load_req) begin
                  state     <= S_HDR;
                  in_ready  <= 1'b1;
                  done      <= 1'b0;
                  cpu_rst_n <= 1'b0;
               end
            end
            S_ERR: begin
               if (load_req) begin
                  state    <= S_HDR;
                  in_ready <= 1'b1;
                  err      <= 1'b0;
               end
            end
            default: begin
               state    <= S_IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader: the write-side counterpart of the CPU instruction fetch path.
- Receives a framed program over a valid/ready byte interface and assembles 32-bit instruction words.
- Writes each word into the 32-entry instruction memory.
- Holds the CPU in reset (cpu_rst_n low) until a complete, valid program has been loaded, then releases it.

Parameters:
- DEPTH, 32, number of instruction-memory words; maximum legal word count.
- ADDR_W, 5, instruction-memory address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous, active-low reset.
- load_req  input  1  level; starts a load when the FSM is in IDLE, DONE or ERR.
- in_valid  input  1  byte stream valid.
- in_data  input  8  byte stream data.
- in_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one-cycle pulse per word.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  32  assembled instruction word.
- cpu_rst_n  output  1  CPU reset; low = CPU held in reset.
- done  output  1  load completed successfully.
- err  output  1  load failed (bad count or bad checksum).

Behaviour:
- Frame format: header byte N, then 4*N data bytes (big-endian: first byte -> wdata[31:24]), then one checksum byte.
- Checksum byte = XOR of the header byte and all data bytes.
- Handshake: a byte transfers on a rising clk edge with in_valid=1 and in_ready=1. The source may stall (in_valid=0) at any byte; no transfer occurs and no state changes.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_rst_n=0, done=0, err=0.
  - Internal byte index, word index, word count and XOR accumulator all cleared.
- States:
  - IDLE: in_ready=0. load_req=1 -> HDR.
  - HDR: in_ready=1. On transfer: N=in_data. N==0 or N>DEPTH -> ERR; otherwise store N, acc=in_data, word index=0, byte index=0 -> DATA.
  - DATA: in_ready=1.
    - Each transfer shifts in_data into the word register and XORs it into acc.
    - On the 4th byte of a word, the next cycle drives imem_we=1 for exactly one cycle, with imem_addr=word index and imem_wdata=the assembled word.
    - Word index increments after the write. After word N-1 -> CSUM (checksum compiled in) or DONE.
    - A byte accepted in the same cycle imem_we is high is legal and is not lost.
  - CSUM: in_ready=1. On transfer: in_data==acc -> DONE, else -> ERR.
  - DONE: in_ready=0, done=1, cpu_rst_n=1. load_req=1 -> HDR, with done=0 and cpu_rst_n=0 from the next cycle.
  - ERR: in_ready=0, err=1, cpu_rst_n=0. load_req=1 -> HDR, with err=0 from the next cycle.
- load_req is ignored in HDR, DATA and CSUM.
- Boundary conditions:
  - imem_addr never wraps. With N=DEPTH the last write is to address DEPTH-1, and no further write follows.
  - Reset mid-load discards any partial word. Words already written stay in memory. cpu_rst_n goes low.
  - The final data byte and imem_we of the last word: the DONE/CSUM transition occurs on the cycle of the last word's imem_we pulse. done rises no earlier than that pulse.
- imem_we is never high in IDLE, HDR, DONE or ERR, apart from the trailing pulse of the last word.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined: CSUM state present; the frame ends with the checksum byte; a mismatch -> ERR.
- Undefined: no CSUM state and no XOR accumulator; the frame ends after the last data byte, and DATA goes directly to DONE. err is raised only for an illegal N.

Test Plan:
- Two-word load (checksum enabled):
  - Stimulus: load_req, then bytes 02,12,34,56,78,9A,BC,DE,F0,02.
  - Response: imem_we pulses write addr0=0x12345678 and addr1=0x9ABCDEF0; done=1, cpu_rst_n=1, err=0.
- Stalls:
  - Stimulus: same frame as above, with in_valid dropped for 3 cycles between every byte.
  - Response: identical writes and final state; no extra imem_we pulses.
- Illegal count:
  - Stimulus: header 0x00, then separately header 0x21.
  - Response: ERR, err=1, cpu_rst_n=0, no imem_we.
- Bad checksum then retry:
  - Stimulus: the two-word frame with checksum 0x03.
  - Response: ERR, cpu_rst_n stays 0. Then load_req with checksum 0x02 -> done=1.
- Full depth:
  - Stimulus: N=0x20, word k = {4{k[7:0]}}.
  - Response: 32 writes, addresses 0..31 in order; no write after address 31; done=1.
- Reset mid-load:
  - Stimulus: rst_n=0 after 6 data bytes of a two-word frame.
  - Response: all outputs at reset values, state IDLE. Exactly one write (addr0) occurred before reset.
